// File: rtl/mul_xbar_accumulator_pkg.sv
// Shared types and constants for the multiplier-array receive side: the product
// beat (MUL_DATA), the drained entry (ACC_ENTRY) and the accumulator geometry.
package mul_xbar_accumulator_pkg;

  localparam int LANES  = 16;
  localparam int BANKS  = 8;
  localparam int DEPTH  = 32;
  localparam int PROD_W = 16;
  localparam int ACC_W  = 24;
  localparam int AW     = $clog2(BANKS * DEPTH);
  localparam int BW     = $clog2(BANKS);
  localparam int RW     = $clog2(DEPTH);

  typedef struct packed {
    logic [LANES-1:0][PROD_W-1:0] output_data;
    logic [LANES-1:0]             valid;
  } MUL_DATA;

  typedef struct packed {
    logic [AW-1:0]    addr;
    logic [ACC_W-1:0] data;
  } ACC_ENTRY;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  function automatic logic [ACC_W-1:0] sext_prod(input logic [PROD_W-1:0] p);
    return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
  endfunction

endpackage

// File: rtl/mul_xbar_accumulator_bank_conflict_arbiter.sv
// Per-bank lowest-index pick over a pending lane mask; purely combinational.
// Lanes not granted this cycle are returned in remain_o for the next round.
module bank_conflict_arbiter #(
  parameter int LANES = 16,
  parameter int BANKS = 8,
  parameter int BW    = $clog2(BANKS)
) (
  input  logic [LANES-1:0]         pend_i,
  input  logic [LANES-1:0][BW-1:0] bank_id_i,
  output logic [LANES-1:0]         grant_o,
  output logic [LANES-1:0]         remain_o
);

  logic [BANKS-1:0] claimed_s;

  // Walk lanes in index order; the first pending lane per bank claims it
  always_comb begin
    grant_o   = '0;
    claimed_s = '0;
    for (int l = 0; l < LANES; l++) begin
      if (pend_i[l] && !claimed_s[bank_id_i[l]]) begin
        grant_o[l]               = 1'b1;
        claimed_s[bank_id_i[l]]  = 1'b1;
      end else begin
        grant_o[l] = 1'b0;
      end
    end
    remain_o = pend_i & ~grant_o;
  end

endmodule

// File: rtl/mul_xbar_accumulator.sv
// Scatters one beat of lane products into banked accumulators, serialising
// same-bank collisions, and drains the whole array on a partial-sum tile end.
module mul_xbar_accumulator
  import mul_xbar_accumulator_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  MUL_DATA                  mul_in,
  input  logic [LANES-1:0][AW-1:0] addr_in,
  input  logic                     partial_c_in,
  output logic                     stall,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [AW-1:0]            out_addr,
  output logic [ACC_W-1:0]         out_data,
  output logic                     drain_done
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(BANKS * DEPTH - 1);

  state_e                       state_q, state_d;
  logic [LANES-1:0]             mask_q, mask_d;
  logic [LANES-1:0][PROD_W-1:0] prod_q;
  logic [LANES-1:0][AW-1:0]     addr_q;
  logic                         part_q, part_d;
  logic [AW-1:0]                drain_addr_q, drain_addr_d;
  logic                         drain_done_q, drain_done_d;

  logic                         idle_s, capture_s, go_drain_s, hs_s;
  logic [LANES-1:0]             pend_s, grant_s, remain_s;
  logic [LANES-1:0][BW-1:0]     bank_id_s;
  logic [BANKS-1:0]             bank_we_s;
  logic [BANKS-1:0][RW-1:0]     bank_row_s;
  logic [BANKS-1:0][ACC_W-1:0]  bank_val_s;
  logic [BANKS-1:0][ACC_W-1:0]  bank_rd_s;
  logic [BW-1:0]                drain_bank_s;
  logic [RW-1:0]                drain_row_s;

  // Commit runs only in IDLE, so the arbiter sees an empty mask while draining
  assign idle_s       = (state_q == ST_IDLE);
  assign pend_s       = idle_s ? mask_q : '0;
  assign stall        = (remain_s != '0) || !idle_s;
  assign capture_s    = !stall;
  assign go_drain_s   = idle_s && (remain_s == '0) && part_q;
  assign hs_s         = !idle_s && out_ready;
  assign drain_bank_s = drain_addr_q[BW-1:0];
  assign drain_row_s  = drain_addr_q[AW-1:BW];

  // Bank select is the low address bits of each pending lane
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      bank_id_s[l] = addr_q[l][BW-1:0];
    end
  end

  bank_conflict_arbiter #(
    .LANES (LANES),
    .BANKS (BANKS)
  ) u_arb (
    .pend_i    (pend_s),
    .bank_id_i (bank_id_s),
    .grant_o   (grant_s),
    .remain_o  (remain_s)
  );

  // Route each bank's single granted lane to that bank's write port
  always_comb begin
    bank_we_s  = '0;
    bank_row_s = '0;
    bank_val_s = '0;
    for (int b = 0; b < BANKS; b++) begin
      for (int l = 0; l < LANES; l++) begin
        if (grant_s[l] && (bank_id_s[l] == BW'(b))) begin
          bank_we_s[b]  = 1'b1;
          bank_row_s[b] = addr_q[l][AW-1:BW];
          bank_val_s[b] = sext_prod(prod_q[l]);
        end else begin
          bank_we_s[b] = bank_we_s[b];
        end
      end
    end
  end

  // Pending-beat next state: a fresh beat replaces an exhausted one
  always_comb begin
    mask_d = mask_q;
    part_d = part_q;
    if (capture_s) begin
      mask_d = mul_in.valid;
      part_d = partial_c_in;
    end else if (idle_s) begin
      mask_d = remain_s;
    end else begin
      mask_d = mask_q;
    end
  end

  // FSM next state: tile end triggers a full in-order walk of the array
  always_comb begin
    state_d      = state_q;
    drain_addr_d = drain_addr_q;
    drain_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (go_drain_s) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (hs_s && (drain_addr_q == LAST_ADDR)) begin
          state_d      = ST_IDLE;
          drain_addr_d = '0;
          drain_done_d = 1'b1;
        end else if (hs_s) begin
          drain_addr_d = drain_addr_q + AW'(1);
        end else begin
          drain_addr_d = drain_addr_q;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        drain_addr_d = '0;
      end
    endcase
  end

  // Control and pending-beat registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      mask_q       <= '0;
      part_q       <= 1'b0;
      prod_q       <= '0;
      addr_q       <= '0;
      drain_addr_q <= '0;
      drain_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      part_q       <= part_d;
      drain_addr_q <= drain_addr_d;
      drain_done_q <= drain_done_d;
      if (capture_s) begin
        prod_q <= mul_in.output_data;
        addr_q <= addr_in;
      end
    end
  end

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic [ACC_W-1:0] acc_q [DEPTH];

    // One read-modify-write per bank per cycle; commit and drain never overlap
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int r = 0; r < DEPTH; r++) begin
          acc_q[r] <= '0;
        end
      end else if (bank_we_s[b]) begin
        acc_q[bank_row_s[b]] <= acc_q[bank_row_s[b]] + bank_val_s[b];
      end else if (hs_s && (drain_bank_s == BW'(b))) begin
        acc_q[drain_row_s] <= '0;
      end
    end

    assign bank_rd_s[b] = acc_q[drain_row_s];
  end

  assign out_valid  = !idle_s;
  assign out_addr   = drain_addr_q;
  assign out_data   = idle_s ? '0 : bank_rd_s[drain_bank_s];
  assign drain_done = drain_done_q;

endmodule
